// File: rtl/shift_add_mul_ctrl.sv
// Shift-and-add unsigned multiplier sharing one 16-bit ripple adder.
// Define MUL_EARLY_TERM_EN to leave RUN once no multiplier bits remain.

module Add16Bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s
);

  wire [15:0] p;
  wire [15:0] c;
  wire [15:0] s_w;
  wire [14:0] g;
  wire [14:0] t;

  assign c[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_bit
      xor x_p (p[i], a[i], b[i]);
      xor x_s (s_w[i], p[i], c[i]);
      // top bit has no carry-out
      if (i < 15) begin : g_carry
        and a_g (g[i], a[i], b[i]);
        and a_t (t[i], p[i], c[i]);
        or  o_c (c[i+1], g[i], t[i]);
      end
    end
  endgenerate

  assign s = s_w;

endmodule

module shift_add_mul_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [15:0]      product
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [15:0]      mcand_reg;
  logic [15:0]      product_acc;
  logic [15:0]      sum;
  logic [WIDTH-1:0] mplr_reg;
  logic [WIDTH-1:0] mplr_sh;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last;

  Add16Bit u_add (
    .a (product_acc),
    .b (mcand_reg),
    .s (sum)
  );

  assign mplr_sh = mplr_reg >> 1;
  assign accept  = start && (state == IDLE || state == DONE);

`ifdef MUL_EARLY_TERM_EN
  assign last = (count == CNT_W'(1)) || (mplr_sh == '0);
`else
  assign last = (count == CNT_W'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg   <= '0;
      mplr_reg    <= '0;
      count       <= '0;
      product_acc <= '0;
    end else if (accept) begin
      mcand_reg   <= 16'(a);
      mplr_reg    <= b;
      count       <= CNT_W'(WIDTH);
      product_acc <= '0;
    end else if (state == RUN) begin
      if (mplr_reg[0]) begin
        product_acc <= sum;
      end
      mcand_reg <= mcand_reg << 1;
      mplr_reg  <= mplr_sh;
      count     <= count - CNT_W'(1);
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = product_acc;

endmodule
